// File: rtl/da_pkg.sv
// da_pkg: shared FSM state type, default widths and the LUT subset-sum helper for da_serial_sched.
package da_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam int DA_W     = 4;
    localparam int DA_CW    = 4;
    localparam int DA_YW    = 8;
    localparam int MAX_TAPS = 4;
    // Two guard bits absorb the growth of the signed DA sum before it is sized to YW.
    function automatic int acc_w(input int yw);
        return yw + 2;
    endfunction
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    function automatic int lut_sum(input int addr, input logic [MAX_TAPS-1:0][31:0] coeffs);
        int s = 0;
        for (int k = 0; k < MAX_TAPS; k++) if (addr[k]) s += int'(coeffs[k]);
        return s;
    endfunction
endpackage

// File: rtl/da_lut.sv
// da_lut: combinational 2^TAPS-entry DA table; entry a is the sum of the coefficients selected by the bits of a.
module da_lut
    import da_pkg::*;
#(
    parameter int TAPS = 4,
    parameter int CW   = 4,
    parameter int C0   = 2,
    parameter int C1   = 3,
    parameter int C2   = 1,
    parameter int C3   = 1
) (
    input  logic [TAPS-1:0]      i_addr,
    output logic signed [CW-1:0] o_val
);
    localparam logic [MAX_TAPS-1:0][31:0] COEFFS = {32'(C3), 32'(C2), 32'(C1), 32'(C0)};
    localparam int LMAX = (1 << (CW - 1)) - 1;
    logic signed [CW-1:0] w_tab [2**TAPS];
    if (TAPS > MAX_TAPS) begin : g_taps_err
        $error("da_lut: TAPS exceeds the number of coefficient parameters");
    end
    for (genvar a = 0; a < 2**TAPS; a++) begin : g_tab
        localparam int S = lut_sum(a, COEFFS);
        if (S > LMAX || S < -LMAX - 1) begin : g_ovf
            $error("da_lut: LUT entry %0d overflows CW bits", a);
        end
        assign w_tab[a] = CW'(S);
    end
    assign o_val = w_tab[i_addr];
endmodule

// File: rtl/da_serial_sched.sv
// da_serial_sched: bit-serial distributed-arithmetic FIR sequencer (tap line, bit counter, accumulator).
// Define DA_SAT_EN to saturate y to the signed YW range; otherwise y wraps to the low YW bits.
module da_serial_sched
    import da_pkg::*;
#(
    parameter int W    = DA_W,
    parameter int TAPS = 4,
    parameter int C0   = 2,
    parameter int C1   = 3,
    parameter int C2   = 1,
    parameter int C3   = 1,
    parameter int CW   = DA_CW,
    parameter int YW   = DA_YW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W-1:0]  x_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [YW-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int AW = acc_w(YW);
    localparam int BW = cnt_w(W);
    state_t r_state, w_next;
    logic signed [W-1:0]  r_tap [TAPS];
    logic [W-1:0]         r_work [TAPS];
    logic signed [AW-1:0] r_acc, w_term, w_acc_nxt;
    logic [BW-1:0]        r_bitcnt;
    logic signed [YW-1:0] r_y, w_y;
    logic [TAPS-1:0]      w_addr;
    logic signed [CW-1:0] w_lut;
    logic                 w_last, w_take;

    da_lut #(.TAPS(TAPS), .CW(CW), .C0(C0), .C1(C1), .C2(C2), .C3(C3)) u_lut (
        .i_addr (w_addr),
        .o_val  (w_lut)
    );

    for (genvar k = 0; k < TAPS; k++) begin : g_addr
        assign w_addr[k] = r_work[k][0];
    end

    assign w_take    = (r_state == IDLE) && in_valid;
    assign w_last    = r_bitcnt == BW'(W - 1);
    assign w_term    = AW'(w_lut) <<< r_bitcnt;
    // The final (sign) bit of a two's-complement sample carries negative weight.
    assign w_acc_nxt = w_last ? r_acc - w_term : r_acc + w_term;
`ifdef DA_SAT_EN
    localparam logic signed [AW-1:0] YMAX = AW'((1 << (YW - 1)) - 1);
    localparam logic signed [AW-1:0] YMIN = AW'(-(1 << (YW - 1)));
    assign w_y = (w_acc_nxt > YMAX) ? YMAX[YW-1:0] : (w_acc_nxt < YMIN) ? YMIN[YW-1:0] : w_acc_nxt[YW-1:0];
`else
    assign w_y = w_acc_nxt[YW-1:0];
`endif
    assign y = r_y;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_next   = in_valid ? RUN : IDLE;
            end
            RUN:  w_next = w_last ? HOLD : RUN;
            HOLD: begin
                out_valid = 1'b1;
                w_next    = out_ready ? IDLE : HOLD;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_bitcnt <= '0;
            r_y      <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_tap[k]  <= '0;
                r_work[k] <= '0;
            end
        end else if (w_take) begin
            r_tap[0]  <= x_in;
            r_work[0] <= x_in;
            for (int k = 1; k < TAPS; k++) begin
                r_tap[k]  <= r_tap[k-1];
                r_work[k] <= r_tap[k-1];
            end
            r_acc    <= '0;
            r_bitcnt <= '0;
        end else if (r_state == RUN) begin
            for (int k = 0; k < TAPS; k++) r_work[k] <= r_work[k] >> 1;
            r_acc <= w_acc_nxt;
            if (w_last) r_y <= w_y;
            else r_bitcnt <= r_bitcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_da_serial_sched.sv
// tb_da_serial_sched: directed scoreboard bench for da_serial_sched; a YW=6 instance checks wrap or DA_SAT_EN saturation.
module tb_da_serial_sched;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [3:0] x_in = '0;
    logic in_ready, out_valid, busy, in_ready6, out_valid6, busy6, took;
    logic signed [7:0] y;
    logic signed [5:0] y6;
    int n_vec = 0, n_err = 0, cyc = 0, n_pop = 0;
    int m_tap [4] = '{0, 0, 0, 0};
    int q [$];

    always #5 clk = ~clk;

    da_serial_sched dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );
    da_serial_sched #(.YW(6)) dut6 (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready6),
        .y(y6), .out_valid(out_valid6), .out_ready(out_ready), .busy(busy6)
    );

    function automatic int wrap(input int v, input int b);
        return (v <<< (32 - b)) >>> (32 - b);
    endfunction

    function automatic int exp6(input int v);
`ifdef DA_SAT_EN
        return (v > 31) ? 31 : (v < -32) ? -32 : v;
`else
        return wrap(v, 6);
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake about to complete, then advance to #1 after the edge.
    task automatic tick();
        took = 1'b0;
        if (!reset && out_valid && out_ready) begin
            n_pop++;
            chk("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                int v = q.pop_front();
                chk("y", y, wrap(v, 8));
                chk("y6", y6, exp6(v));
                chk("out_valid6", out_valid6, 1);
            end
        end
        if (!reset && in_valid && in_ready) begin
            for (int k = 3; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = x_in;
            q.push_back(2 * m_tap[0] + 3 * m_tap[1] + m_tap[2] + m_tap[3]);
            chk("in_ready6", in_ready6, 1);
            took = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int x);
        int g = 0;
        x_in = 4'(x);
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 100) begin
            tick();
            g++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int lat, e, n, prev, p0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy6", busy6, 0);
        chk("rst_y", y, 0);
        // Impulse response and first-output latency.
        out_ready = 1'b1;
        send(1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, 5);
        repeat (4) send(0);
        drain();
        // Negative impulse exercises the sign-bit subtract.
        send(-8);
        repeat (4) send(0);
        drain();
        // Steady input grows past the YW=6 range.
        repeat (6) send(7);
        drain();
        // Backpressure: output held, offered sample not consumed.
        out_ready = 1'b0;
        send(5);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_valid", out_valid, 1);
        e = (q.size() > 0) ? q[0] : 999;
        x_in = 4'(3);
        in_valid = 1'b1;
        repeat (10) begin
            chk("bp_y", y, wrap(e, 8));
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_took", took, 1);
        chk("bp_run", busy, 1);
        in_valid = 1'b0;
        drain();
        // Reset in RUN at bitcnt=2 abandons the sample and clears the taps.
        send(6);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_tap = '{0, 0, 0, 0};
        q.delete();
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_y", y, 0);
        send(1);
        repeat (3) send(0);
        drain();
        // Back-to-back stream with in_valid and out_ready held high.
        n = 0;
        prev = 0;
        p0 = n_pop;
        in_valid = 1'b1;
        x_in = 4'($urandom_range(0, 15));
        for (int i = 0; i < 300 && n < 20; i++) begin
            tick();
            if (took) begin
                n++;
                if (n > 1) chk("b2b_gap", cyc - prev, 6);
                prev = cyc;
                x_in = 4'($urandom_range(0, 15));
            end
        end
        in_valid = 1'b0;
        drain();
        chk("b2b_accepts", n, 20);
        chk("b2b_outputs", n_pop - p0, 20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/da_serial_sched.md
Name: da_serial_sched

Overview:
- Sequencer for a bit-serial distributed-arithmetic (DA) FIR filter with TAPS taps.
- Accepts one sample per valid/ready handshake and pushes it into the tap delay line.
- Steps a bit counter over W cycles, LSB first, and drives the LUT address and the accumulator add/subtract control.
- Presents the finished filter output on a valid/ready output port. Sits between the sample source and downstream filter stages, and replaces the per-bit parallel tables where area matters.

Parameters:
- W, 4, input sample width; also the number of RUN cycles per output.
- TAPS, 4, number of filter taps; the LUT has 2^TAPS entries.
- C0, 2, signed coefficient of tap 0 (newest sample).
- C1, 3, signed coefficient of tap 1.
- C2, 1, signed coefficient of tap 2.
- C3, 1, signed coefficient of tap 3 (oldest sample).
- CW, 4, signed coefficient and LUT-entry width.
- YW, 8, signed output width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- x_in  in  W  signed input sample.
- in_valid  in  1  x_in is valid this cycle.
- in_ready  out  1  block can accept a sample; high only in IDLE.
- y  out  YW  signed filter output.
- out_valid  out  1  y is valid; held until consumed.
- out_ready  in  1  downstream accepts y.
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk and reset).
- Reset values: state=IDLE, taps=0, working registers=0, acc=0, bitcnt=0, y=0, out_valid=0, busy=0. in_ready=1 in the cycle after reset.
- Reset in any state, including mid-RUN, abandons the computation. No output is produced for the abandoned sample.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid: tap[k]<=tap[k-1] for k=TAPS-1..1, and tap[0]<=x_in. Copy the post-shift taps into working registers; acc<=0, bitcnt<=0; go to RUN.
  - RUN: LUT address bit k is the LSB of working register k. Each cycle, shift each working register right by 1.
    - bitcnt<W-1: acc <= acc + (LUT << bitcnt).
    - bitcnt=W-1 (sign bit): acc <= acc - (LUT << (W-1)), then go to HOLD.
    - Otherwise bitcnt increments.
  - HOLD: y<=acc, sized to YW (see Optional Feature), and out_valid=1 from the first HOLD cycle. Stay until out_ready=1, then clear out_valid and go to IDLE.
- LUT[a] is the sum of Ck over all k with bit k of a set, signed, CW bits. Coefficients whose sums overflow CW are a configuration error, checked by an elaboration assertion.
- Accumulator width is YW+2 bits, signed; all shifts are arithmetic.
- Latency: a handshake at cycle 0 gives out_valid at cycle W+1. Peak throughput is one sample per W+2 cycles.
- in_valid outside IDLE is ignored; the sample is not consumed and the source must hold it.
- y and out_valid are stable while out_ready=0.
- out_ready asserted outside HOLD has no effect.

Optional Feature:
- Macro: DA_SAT_EN.
- Defined: y is acc saturated to the signed YW range, i.e. clipped to [-2^(YW-1), 2^(YW-1)-1].
- Undefined: y is the low YW bits of acc (two's-complement wrap).

Decomposition:
- Package da_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - width constants derived from W, CW and YW;
  - a function lut_sum(addr, coeffs) returning the subset sum.
- Sub-module da_lut: combinational 2^TAPS-entry table built from the coefficient parameters. The sequencer, tap line and accumulator stay in the top module.

Test Plan:
- Impulse: x_in=1, then 0,0,0,0 with out_ready=1 -> y=2,3,1,1,0. First out_valid arrives exactly 5 cycles after the first handshake.
- Negative impulse: x_in=-8, then zeros -> y=-16,-24,-8,-8,0. This checks the sign-bit subtract.
- Steady input x_in=7 for 6 samples -> y=14,35,42,49,49,49. Repeat with YW=6: DA_SAT_EN defined gives 31 for every y above 31; undefined gives wrap (49 becomes -15).
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> y and out_valid stable, in_ready=0, a sample offered on in_valid is not consumed. On release, the held sample is accepted 1 cycle after the return to IDLE.
- Reset mid-RUN at bitcnt=2 -> next cycle state=IDLE, out_valid=0, taps=0. A following impulse of 1 gives y=2.
- Back-to-back stream: in_valid and out_ready tied high for 20 samples -> in_ready pulses exactly once every W+2 cycles, with no dropped or duplicated output.
